// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation controller.
package sar_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_DECIDE = 2'd2
   } sar_state_e;

   localparam int unsigned DEF_WIDTH  = 8;
   localparam int unsigned DEF_SETTLE = 2;

   function automatic int unsigned settle_cnt_w(input int unsigned settle);
      return $clog2(settle) + 1;
   endfunction

   localparam int unsigned SETTLE_CNT_W = settle_cnt_w(DEF_SETTLE);

endpackage

// File: rtl/sar_settle_timer.sv
// Counts the hold time of each trial code; terminal count at SETTLE-1.
module sar_settle_timer
   import sar_pkg::*;
#(
   parameter int unsigned SETTLE = DEF_SETTLE
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc_c
);

   localparam int unsigned CNT_W = settle_cnt_w(SETTLE);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_tc;

   assign w_tc   = (r_cnt == CNT_LAST);
   assign o_tc_c = w_tc;

   // Wraps to zero on terminal count so the next bit starts clean.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr || (i_en && w_tc)) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/sar_ctrl.sv
// SAR conversion controller: trial-code generation, bit decisions, start/busy/done handshake.
module sar_ctrl
   import sar_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned SETTLE = DEF_SETTLE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             comp_in,
   output logic [WIDTH-1:0] dac_code,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int unsigned      IDX_W    = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MSB_CODE = {1'b1, {(WIDTH-1){1'b0}}};

   sar_state_e       r_state, w_state_nxt;
   logic [IDX_W-1:0] r_idx, w_idx_nxt, w_idx_dec;
   logic [WIDTH-1:0] r_dac, w_dac_nxt;
   logic [WIDTH-1:0] r_result, w_result_nxt;
   logic             r_done, w_done_nxt;
   logic             r_busy;
   logic             w_tmr_clr, w_tmr_en, w_tmr_tc;

   sar_settle_timer #(
      .SETTLE (SETTLE)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_tmr_clr),
      .i_en   (w_tmr_en),
      .o_tc_c (w_tmr_tc)
   );

   assign w_idx_dec = r_idx - IDX_W'(1);

   // Next-state and datapath decode.
   always_comb begin
      w_state_nxt  = r_state;
      w_idx_nxt    = r_idx;
      w_dac_nxt    = r_dac;
      w_result_nxt = r_result;
      w_done_nxt   = 1'b0;
      w_tmr_clr    = 1'b0;
      w_tmr_en     = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_dac_nxt   = MSB_CODE;
               w_idx_nxt   = IDX_TOP;
               w_tmr_clr   = 1'b1;
               w_state_nxt = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            w_tmr_en = 1'b1;
            if (w_tmr_tc) begin
               w_state_nxt = ST_DECIDE;
            end
         end
         ST_DECIDE: begin
            w_dac_nxt[r_idx] = comp_in;
            if (r_idx != '0) begin
               w_dac_nxt[w_idx_dec] = 1'b1;
               w_idx_nxt            = w_idx_dec;
               w_state_nxt          = ST_SETTLE;
            end else begin
               w_result_nxt = w_dac_nxt;
               w_done_nxt   = 1'b1;
               w_state_nxt  = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Abort overrides any in-flight step, including the final decision.
      if (abort && (r_state != ST_IDLE)) begin
         w_state_nxt  = ST_IDLE;
         w_dac_nxt    = '0;
         w_idx_nxt    = IDX_TOP;
         w_result_nxt = r_result;
         w_done_nxt   = 1'b0;
         w_tmr_en     = 1'b0;
         w_tmr_clr    = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_idx    <= IDX_TOP;
         r_dac    <= '0;
         r_result <= '0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_idx    <= w_idx_nxt;
         r_dac    <= w_dac_nxt;
         r_result <= w_result_nxt;
         r_done   <= w_done_nxt;
         r_busy   <= (w_state_nxt != ST_IDLE);
      end
   end

   assign dac_code = r_dac;
   assign busy     = r_busy;
   assign done     = r_done;
   assign result   = r_result;

endmodule

// File: tb/tb_sar_ctrl.sv
// Directed bench for sar_ctrl: default 8-bit/SETTLE=2 build plus a 4-bit/SETTLE=1 build.
module tb_sar_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, abort;
   logic [7:0] vin;
   logic       comp8;
   logic [7:0] dac_code, result;
   logic       busy, done;

   logic       start4;
   logic [3:0] vin4;
   logic       comp4;
   logic [3:0] dac4, result4;
   logic       busy4, done4;

   int n_checks = 0;
   int n_errors = 0;
   int n_done8  = 0;

   logic [7:0] codes_a5 [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
   logic [3:0] codes_9  [4] = '{4'h8, 4'hC, 4'hA, 4'h9};

   always #5 clk = ~clk;

   assign comp8 = (vin >= dac_code);
   assign comp4 = (vin4 >= dac4);

   sar_ctrl #(.WIDTH(8), .SETTLE(2)) dut (
      .clk (clk), .rst_n (rst_n), .start (start), .abort (abort), .comp_in (comp8),
      .dac_code (dac_code), .busy (busy), .done (done), .result (result)
   );

   sar_ctrl #(.WIDTH(4), .SETTLE(1)) dut4 (
      .clk (clk), .rst_n (rst_n), .start (start4), .abort (1'b0), .comp_in (comp4),
      .dac_code (dac4), .busy (busy4), .done (done4), .result (result4)
   );

   always @(negedge clk) if (done) n_done8 <= n_done8 + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full 8-bit conversion launched by a single start pulse.
   task automatic run8(input logic [7:0] v, input logic [7:0] exp, input bit chk_codes);
      int d0;
      vin   = v;
      start = 1'b1;
      tick();
      start = 1'b0;
      d0    = n_done8;
      for (int c = 0; c < 24; c++) begin
         if (chk_codes) check("trial_code", 32'(dac_code), 32'(codes_a5[c/3]));
         check("busy_conv", 32'(busy), 32'd1);
         check("done_early", 32'(done), 32'd0);
         tick();
      end
      check("done_pulse", 32'(done), 32'd1);
      check("busy_done", 32'(busy), 32'd0);
      check("result", 32'(result), 32'(exp));
      check("final_code", 32'(dac_code), 32'(exp));
      tick();
      check("done_width", 32'(done), 32'd0);
      check("result_hold", 32'(result), 32'(exp));
      check("done_count", 32'(n_done8 - d0), 32'd1);
   endtask

   initial begin
      int d0;
      rst_n  = 1'b0;
      start  = 1'b0;
      abort  = 1'b0;
      vin    = '0;
      start4 = 1'b0;
      vin4   = '0;
      #3;
      check("rst_dac", 32'(dac_code), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      run8(8'hA5, 8'hA5, 1'b1);
      run8(8'h00, 8'h00, 1'b0);
      run8(8'hFF, 8'hFF, 1'b0);

      // start held high for the whole conversion and into the done cycle
      vin   = 8'h3C;
      start = 1'b1;
      tick();
      d0 = n_done8;
      for (int c = 0; c < 24; c++) begin
         check("held_busy", 32'(busy), 32'd1);
         tick();
      end
      check("held_done", 32'(done), 32'd1);
      check("held_result", 32'(result), 32'h3C);
      check("held_busy_done", 32'(busy), 32'd0);
      tick();
      start = 1'b0;
      check("b2b_dac", 32'(dac_code), 32'h80);
      check("b2b_busy", 32'(busy), 32'd1);
      check("held_done_count", 32'(n_done8 - d0), 32'd1);

      // abort the back-to-back conversion at cycle 10
      repeat (10) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_dac", 32'(dac_code), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_result", 32'(result), 32'h3C);
      d0 = n_done8;
      repeat (30) tick();
      check("abort_no_done", 32'(n_done8 - d0), 32'd0);
      check("abort_result_hold", 32'(result), 32'h3C);

      // start and abort together in IDLE: start wins; abort then cancels
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      check("sa_busy", 32'(busy), 32'd1);
      check("sa_dac", 32'(dac_code), 32'h80);
      tick();
      abort = 1'b0;
      check("sa_abort_busy", 32'(busy), 32'd0);
      check("sa_abort_dac", 32'(dac_code), 32'd0);

      // asynchronous reset in the middle of SETTLE
      vin   = 8'h5A;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_dac", 32'(dac_code), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_result", 32'(result), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      run8(8'h5A, 8'h5A, 1'b0);

      // 4-bit, SETTLE=1 build
      vin4   = 4'h9;
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      for (int c = 0; c < 8; c++) begin
         check("w4_code", 32'(dac4), 32'(codes_9[c/2]));
         check("w4_busy", 32'(busy4), 32'd1);
         check("w4_done_early", 32'(done4), 32'd0);
         tick();
      end
      check("w4_done", 32'(done4), 32'd1);
      check("w4_result", 32'(result4), 32'h9);
      check("w4_busy_done", 32'(busy4), 32'd0);
      tick();
      check("w4_done_width", 32'(done4), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sar_ctrl.md
Name: sar_ctrl

Overview:
Successive-approximation controller that drives the comparator path from the other side. It issues trial DAC codes, samples the 1-bit comparator decision, and builds an N-bit conversion result. It sits upstream of the comparator and produces the codes that comparator-result counting logic consumes. Start/busy/done handshake toward the system side.

Parameters:
WIDTH, 8, conversion resolution in bits (>=2)
SETTLE, 2, cycles each trial code is held before comp_in is sampled (>=1)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request conversion; accepted only in IDLE
abort  input  1  synchronous cancel of a running conversion
comp_in  input  1  comparator decision: 1 = analog input >= dac_code
dac_code  output  WIDTH  trial code driven to DAC; registered
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse, result valid
result  output  WIDTH  last completed conversion; held until next done

Behaviour:
- Reset (async, rst_n=0): state=IDLE, dac_code=0, result=0, busy=0, done=0, bit index=WIDTH-1, settle count=0. Takes effect mid-conversion with no done pulse.
- States: IDLE, SETTLE, DECIDE.
- IDLE: on start=1 at edge E0: dac_code <= 1<<(WIDTH-1), idx <= WIDTH-1, wcnt <= 0, go SETTLE. Otherwise dac_code holds its value (0 after reset or abort, final code after a conversion).
- SETTLE: wcnt increments each cycle. When wcnt==SETTLE-1: wcnt <= 0, go DECIDE. The state lasts exactly SETTLE cycles.
- DECIDE (1 cycle): dac_code[idx] <= comp_in.
  - If idx>0: also set dac_code[idx-1] <= 1, idx <= idx-1, go SETTLE.
  - If idx==0: result <= final code, done <= 1, go IDLE.
- comp_in is sampled only in DECIDE; it is ignored in all other states.
- Latency: each bit costs SETTLE+1 cycles. done is high in the cycle after edge E0 + WIDTH*(SETTLE+1)-1, i.e. WIDTH*(SETTLE+1) cycles after the start edge. Defaults give 24 cycles.
- busy=0 in the done cycle. A start in that same cycle is accepted, so conversions can run back-to-back.
- start while busy: ignored, no queuing.
- abort=1 while busy: next edge goes to IDLE, dac_code <= 0, no done pulse, result unchanged. abort in IDLE has no effect. abort and start together in IDLE: start wins.
- done lasts exactly one cycle. result changes only on the done edge.
- Codes are unsigned. No arithmetic overflow is possible: only single-bit set/clear operations.

Decomposition:
- Shared package sar_pkg: state enum (IDLE, SETTLE, DECIDE), default WIDTH/SETTLE constants, and a localparam for the settle counter width, $clog2(SETTLE)+1.
- One natural sub-module: sar_settle_timer. Clear/enable inputs, terminal-count output at SETTLE-1, same clk/rst_n.
- FSM, bit index and code register stay in sar_ctrl.

Test Plan:
- Bench comp_in model: comp_in = (VIN >= dac_code).
- VIN=0xA5, start pulse:
  - dac_code sequence 80,C0,A0,B0,A8,A4,A6, then final A5.
  - Each trial code is held 3 cycles.
  - done pulse 24 cycles after start edge; result=0xA5; busy low in the done cycle.
- VIN=0x00 -> result=0x00. VIN=0xFF -> result=0xFF. Both with identical 24-cycle latency.
- Start re-asserted every cycle during a conversion with VIN=0x3C:
  - Exactly one done, result=0x3C.
  - start held on the done cycle launches a second conversion immediately; dac_code=0x80 the next cycle.
- abort at cycle 10 of a conversion, previous result=0x3C:
  - Next cycle busy=0, dac_code=0x00.
  - No done pulse; result stays 0x3C.
- rst_n dropped asynchronously mid-SETTLE:
  - All outputs 0 immediately, without a clock edge.
  - After release, a start with VIN=0x5A yields result=0x5A normally.
- SETTLE=1, WIDTH=4 build, VIN=0x9 -> codes 8,C,A,9, result=0x9, done 8 cycles after start.
